ssaes_run_ctrl: RTL and testbench

- Sequencer between the host interface and the 64-bit SSAES cipher unit on the SAKURA-G main FPGA.
- Takes one host command (key, text, mode, iteration count) and issues N back-to-back cipher operations.
- Optionally chains each ciphertext back in as the next input, for multi-trace acquisition per host transaction.
- Drives the cipher start/data inputs, tracks cipher busy, generates the scope trigger, and returns the final result plus status.

---
 rtl/ssaes_run_ctrl_if.sv | 41 ++++
 rtl/ssaes_run_ctrl.sv | 144 ++++++++++++++
 tb/tb_ssaes_run_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ssaes_run_ctrl_if.sv
// Signal bundle between the run sequencer, the host command side and the SSAES cipher core.
// Cipher handshake: aes_start is a one-cycle request. The core raises aes_busy while it works.
// The core's aes_text_out is valid on the first cycle that aes_busy reads low after having been high.
interface ssaes_run_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
);
  logic              host_start;
  logic              host_enc_dec;
  logic [DATA_W-1:0] host_key;
  logic [DATA_W-1:0] host_text;
  logic [CNT_W-1:0]  run_count;
  logic              chain_mode;
  logic              trig_all;
  logic              aes_start;
  logic              aes_enc_dec;
  logic [DATA_W-1:0] aes_key;
  logic [DATA_W-1:0] aes_text_in;
  logic [DATA_W-1:0] aes_text_out;
  logic              aes_busy;
  logic [DATA_W-1:0] result;
  logic [CNT_W-1:0]  iter_done;
  logic              busy;
  logic              done;
  logic              err;
  logic              trig;

  modport slave (
    input  host_start, host_enc_dec, host_key, host_text, run_count, chain_mode, trig_all,
    input  aes_text_out, aes_busy,
    output aes_start, aes_enc_dec, aes_key, aes_text_in,
    output result, iter_done, busy, done, err, trig
  );

  modport master (
    output host_start, host_enc_dec, host_key, host_text, run_count, chain_mode, trig_all,
    output aes_text_out, aes_busy,
    input  aes_start, aes_enc_dec, aes_key, aes_text_in,
    input  result, iter_done, busy, done, err, trig
  );
endinterface

// File: rtl/ssaes_run_ctrl.sv
// Run sequencer: issues N back-to-back SSAES operations per host command, with optional
// ciphertext chaining, scope trigger generation and a busy-rise timeout.
module ssaes_run_ctrl #(
  parameter int DATA_W       = 64,
  parameter int CNT_W        = 16,
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                clock,
  input  logic                reset,
  ssaes_run_ctrl_if.slave     bus,
  output logic [2:0]          state
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    GAP     = 3'd5,
    FINISH  = 3'd6
  } state_t;

  state_t            st;
  logic              aes_start;
  logic              aes_enc_dec;
  logic [DATA_W-1:0] aes_key;
  logic [DATA_W-1:0] aes_text_in;
  logic [DATA_W-1:0] result;
  logic [CNT_W-1:0]  iter_done;
  logic              busy;
  logic              done;
  logic              err;
  logic              trig;
  logic              chain_r;
  logic              trig_all_r;
  logic [CNT_W-1:0]  target;
  logic [TW-1:0]     tmo;
  logic [GW-1:0]     gcnt;
  logic [CNT_W-1:0]  next_iter;

  assign next_iter = iter_done + CNT_W'(1);
  assign state     = st;

  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= IDLE;
      aes_start   <= 1'b0;
      aes_enc_dec <= 1'b0;
      aes_key     <= '0;
      aes_text_in <= '0;
      result      <= '0;
      iter_done   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      trig        <= 1'b0;
      chain_r     <= 1'b0;
      trig_all_r  <= 1'b0;
      target      <= '0;
      tmo         <= '0;
      gcnt        <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (bus.host_start) begin
            aes_key     <= bus.host_key;
            aes_enc_dec <= bus.host_enc_dec;
            aes_text_in <= bus.host_text;
            chain_r     <= bus.chain_mode;
            trig_all_r  <= bus.trig_all;
            target      <= (bus.run_count == '0) ? CNT_W'(1) : bus.run_count;
            iter_done   <= '0;
            err         <= 1'b0;
            busy        <= 1'b1;
            st          <= LOAD;
          end
        end
        LOAD: begin
          aes_start <= 1'b1;
          st        <= START;
        end
        START: begin
          aes_start <= 1'b0;
          trig      <= trig_all_r || (iter_done == '0);
          tmo       <= '0;
          st        <= WAIT_HI;
        end
        WAIT_HI: begin
          // A core that is already busy here is taken as having started.
          if (bus.aes_busy) begin
            st <= WAIT_LO;
          end else if (tmo == TW'(BUSY_TIMEOUT - 1)) begin
            err  <= 1'b1;
            trig <= 1'b0;
            done <= 1'b1;
            st   <= FINISH;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        WAIT_LO: begin
          if (!bus.aes_busy) begin
            result    <= bus.aes_text_out;
            iter_done <= next_iter;
            trig      <= 1'b0;
            if (chain_r) aes_text_in <= bus.aes_text_out;
            if (next_iter == target) begin
              done <= 1'b1;
              st   <= FINISH;
            end else begin
              gcnt <= '0;
              st   <= GAP;
            end
          end
        end
        GAP: begin
          if (gcnt == GW'(GAP_CYCLES - 1)) st <= LOAD;
          else gcnt <= gcnt + GW'(1);
        end
        FINISH: begin
          done <= 1'b0;
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.aes_start   = aes_start;
  assign bus.aes_enc_dec = aes_enc_dec;
  assign bus.aes_key     = aes_key;
  assign bus.aes_text_in = aes_text_in;
  assign bus.result      = result;
  assign bus.iter_done   = iter_done;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.err         = err;
  assign bus.trig        = trig;
endmodule

// File: tb/tb_ssaes_run_ctrl.sv
// Directed bench for ssaes_run_ctrl with a behavioural cipher core that has random busy length.
module tb_ssaes_run_ctrl;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;

  logic       clock;
  logic       reset;
  logic [2:0] state;
  int         n_cmp = 0;
  int         n_err = 0;
  logic       hang  = 1'b0;

  logic [DATA_W-1:0] in_log[$];
  logic [DATA_W-1:0] key_log[$];
  logic              trig_log[$];
  time               start_t[$];
  time               fall_t[$];

  ssaes_run_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  ssaes_run_ctrl #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .GAP_CYCLES(16), .BUSY_TIMEOUT(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .state(state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [DATA_W-1:0] cipher(input logic [DATA_W-1:0] k,
                                               input logic [DATA_W-1:0] t,
                                               input logic ed);
    logic [DATA_W-1:0] r;
    r = ed ? {t[0], t[DATA_W-1:1]} : {t[DATA_W-2:0], t[DATA_W-1]};
    return (r ^ k) + 64'h9E37_79B9_7F4A_7C15;
  endfunction

  // Cipher core model: busy one cycle after start, for 3..20 cycles.
  initial begin
    logic [DATA_W-1:0] m_out;
    int lat;
    bus.aes_busy     = 1'b0;
    bus.aes_text_out = '0;
    forever begin
      @(posedge clock);
      if (bus.aes_start === 1'b1) begin
        in_log.push_back(bus.aes_text_in);
        key_log.push_back(bus.aes_key);
        start_t.push_back($time);
        m_out = cipher(bus.aes_key, bus.aes_text_in, bus.aes_enc_dec);
        if (!hang) begin
          #1 bus.aes_busy = 1'b1;
          lat = $urandom_range(3, 20);
          repeat (lat) @(posedge clock);
          trig_log.push_back(bus.trig);
          fall_t.push_back($time);
          #1;
          bus.aes_busy     = 1'b0;
          bus.aes_text_out = m_out;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    in_log.delete(); key_log.delete(); trig_log.delete();
    start_t.delete(); fall_t.delete();
  endtask

  task automatic launch(input logic [DATA_W-1:0] key, input logic [DATA_W-1:0] text,
                        input logic ed, input logic [CNT_W-1:0] cnt,
                        input logic chain, input logic tall);
    @(negedge clock);
    bus.host_key     = key;
    bus.host_text    = text;
    bus.host_enc_dec = ed;
    bus.run_count    = cnt;
    bus.chain_mode   = chain;
    bus.trig_all     = tall;
    bus.host_start   = 1'b1;
    @(negedge clock);
    bus.host_start   = 1'b0;
  endtask

  // Returns the cycle (host_start cycle = 0) in which done is seen; caller is at cycle 1.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    chk({tag, "_done_seen"}, bus.done, 1'b1);
    @(negedge clock);
    chk({tag, "_done_single"}, bus.done, 1'b0);
    chk({tag, "_busy_low"}, bus.busy, 1'b0);
  endtask

  task automatic wait_core_idle();
    int n = 0;
    while (bus.aes_busy !== 1'b0 && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask

  initial begin
    int cyc;
    int n;
    logic [DATA_W-1:0] exp_v;
    logic [DATA_W-1:0] k1;
    logic [DATA_W-1:0] t1;
    k1 = 64'h0123_4567_89AB_CDEF;
    t1 = 64'h0011_2233_4455_6677;
    bus.host_start = 1'b0; bus.host_enc_dec = 1'b0; bus.host_key = '0; bus.host_text = '0;
    bus.run_count = '0; bus.chain_mode = 1'b0; bus.trig_all = 1'b0;

    // Reset values
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_state", state, 3'd0);
    chk("rst_aes_start", bus.aes_start, 1'b0);
    chk("rst_aes_key", bus.aes_key, '0);
    chk("rst_aes_text_in", bus.aes_text_in, '0);
    chk("rst_aes_enc_dec", bus.aes_enc_dec, 1'b0);
    chk("rst_result", bus.result, '0);
    chk("rst_iter_done", bus.iter_done, '0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_trig", bus.trig, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_aes_start", bus.aes_start, 1'b0);

    // Single encrypt, cycle-by-cycle start latency
    clear_logs();
    launch(k1, t1, 1'b0, 16'd1, 1'b0, 1'b0);
    chk("single_c1_start", bus.aes_start, 1'b0);
    chk("single_c1_busy", bus.busy, 1'b1);
    chk("single_c1_state", state, 3'd1);
    @(negedge clock);
    chk("single_c2_start", bus.aes_start, 1'b1);
    chk("single_c2_key", bus.aes_key, k1);
    chk("single_c2_text", bus.aes_text_in, t1);
    @(negedge clock);
    chk("single_c3_start", bus.aes_start, 1'b0);
    chk("single_c3_trig", bus.trig, 1'b1);
    wait_done("single", cyc);
    chk("single_iter", bus.iter_done, 16'd1);
    chk("single_result", bus.result, cipher(k1, t1, 1'b0));
    chk("single_err", bus.err, 1'b0);
    chk("single_trig_off", bus.trig, 1'b0);
    chk("single_nstart", in_log.size(), 1);

    // run_count = 0 behaves as 1 (decrypt)
    clear_logs();
    launch(64'hFEDC_BA98_7654_3210, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1, 16'd0, 1'b0, 1'b0);
    wait_done("zero", cyc);
    chk("zero_iter", bus.iter_done, 16'd1);
    chk("zero_result", bus.result, cipher(64'hFEDC_BA98_7654_3210, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1));
    chk("zero_nstart", in_log.size(), 1);

    // Chained run of 4, trigger on first operation only
    clear_logs();
    launch(k1, t1, 1'b0, 16'd4, 1'b1, 1'b0);
    wait_done("chain", cyc);
    chk("chain_nstart", in_log.size(), 4);
    exp_v = t1;
    for (int i = 0; i < 4; i++) begin
      if (i < in_log.size()) chk($sformatf("chain_in%0d", i), in_log[i], exp_v);
      exp_v = cipher(k1, exp_v, 1'b0);
    end
    chk("chain_result", bus.result, exp_v);
    chk("chain_iter", bus.iter_done, 16'd4);
    for (int i = 0; i < 4; i++)
      if (i < trig_log.size()) chk($sformatf("chain_trig%0d", i), trig_log[i], (i == 0) ? 1'b1 : 1'b0);
    for (int i = 0; i < 3; i++)
      if (i + 1 < start_t.size() && i < fall_t.size())
        chk($sformatf("chain_gap%0d", i), (start_t[i+1] - 10 - fall_t[i]) / 10, 18);

    // Busy timeout: done in cycle 11, no second start
    clear_logs();
    hang = 1'b1;
    launch(k1, t1, 1'b0, 16'd3, 1'b0, 1'b1);
    wait_done("tmo", cyc);
    chk("tmo_done_cycle", cyc, 11);
    chk("tmo_err", bus.err, 1'b1);
    chk("tmo_iter", bus.iter_done, 16'd0);
    chk("tmo_trig", bus.trig, 1'b0);
    repeat (30) @(negedge clock);
    chk("tmo_nstart", in_log.size(), 1);
    chk("tmo_err_sticky", bus.err, 1'b1);
    hang = 1'b0;

    // host_start mid-run with a different key is ignored
    clear_logs();
    launch(k1, t1, 1'b0, 16'd2, 1'b0, 1'b0);
    chk("mid_err_cleared", bus.err, 1'b0);
    n = 0;
    while (in_log.size() < 1 && n < 100) begin @(negedge clock); n++; end
    bus.host_key   = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.host_text  = 64'h1111_2222_3333_4444;
    bus.host_start = 1'b1;
    @(negedge clock);
    bus.host_start = 1'b0;
    wait_done("mid", cyc);
    chk("mid_nstart", in_log.size(), 2);
    for (int i = 0; i < 2; i++)
      if (i < key_log.size()) chk($sformatf("mid_key%0d", i), key_log[i], k1);
    chk("mid_result", bus.result, cipher(k1, t1, 1'b0));
    chk("mid_iter", bus.iter_done, 16'd2);
    repeat (30) @(negedge clock);
    chk("mid_no_extra", in_log.size(), 2);

    // Reset in WAIT_LO of operation 2 of 5
    clear_logs();
    launch(k1, t1, 1'b0, 16'd5, 1'b1, 1'b1);
    n = 0;
    while (!(in_log.size() == 2 && state == 3'd4) && n < 500) begin @(negedge clock); n++; end
    chk("rst_mid_reached", state, 3'd4);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rstm_state", state, 3'd0);
    chk("rstm_aes_start", bus.aes_start, 1'b0);
    chk("rstm_aes_key", bus.aes_key, '0);
    chk("rstm_aes_text_in", bus.aes_text_in, '0);
    chk("rstm_result", bus.result, '0);
    chk("rstm_iter", bus.iter_done, '0);
    chk("rstm_busy", bus.busy, 1'b0);
    chk("rstm_trig", bus.trig, 1'b0);
    @(negedge clock);
    chk("rstm_after_start", bus.aes_start, 1'b0);
    chk("rstm_after_state", state, 3'd0);
    wait_core_idle();
    clear_logs();
    launch(64'h0F1E_2D3C_4B5A_6978, t1, 1'b0, 16'd1, 1'b0, 1'b0);
    wait_done("rerun", cyc);
    chk("rerun_result", bus.result, cipher(64'h0F1E_2D3C_4B5A_6978, t1, 1'b0));
    chk("rerun_iter", bus.iter_done, 16'd1);
    chk("rerun_nstart", in_log.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
